processing_mem_stream_reader: RTL and testbench
===============================================

# processing_mem_stream_reader

Avalon-MM read master for the 16-bit second port (s2) of a node's processing memory. Software or the node controller hands it a start halfword address and a length. The block reads that many consecutive halfwords, wrapping at the memory top, and presents them in order on a valid/ready stream with a last marker. It is the consumer-side counterpart of the dual-port processing memory: the Nios writes through s1, and this block drains through s2.

## Interface
Parameters:
- `MEM_WORDS`, 20480: halfword depth of the s2 port; addresses wrap from MEM_WORDS-1 to 0.
- `ADDR_W`, 15: width of the s2 address and of `cmd_addr`.
- `LEN_W`, 15: width of `cmd_len`.
- `FIFO_DEPTH`, 4: output buffer entries; fixed at 4 (credit rule below depends on it).

Ports:
- `clk` in 1: single clock; the memory shares this clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_addr` in ADDR_W: first halfword address; must be < MEM_WORDS.
- `cmd_len` in LEN_W: number of halfwords; 0 is legal.
- `mem_address` out ADDR_W: to s2 address.
- `mem_chipselect` out 1: high in each cycle a read is issued.
- `mem_clken` out 1: constant 1.
- `mem_write` out 1: constant 0.
- `mem_byteenable` out 2: constant 2'b11.
- `mem_writedata` out 16: constant 0.
- `mem_readdata` in 16: s2 readdata (unregistered RAM output).
- `out_valid` out 1: stream word available.
- `out_ready` in 1: consumer accepts.
- `out_data` out 16: halfword.
- `out_last` out 1: marks the final halfword of a command.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr and len.
    - len≠0: go to READ.
    - len=0: register `done` and stay in IDLE.
  - READ: issue reads under the credit rule. After the final issue, go to DRAIN.
  - DRAIN: wait for the last word to be popped. Then register `done` and go to IDLE.
- Read issue:
  - `mem_address` and `mem_chipselect` are registered outputs.
  - A read is issued when `remaining`≠0 and `fifo_count + inflight` ≤ 2, using registered values only. There is no combinational path from `out_ready` to the memory outputs.
  - Each issue decrements `remaining` and advances the address by 1. The address wraps MEM_WORDS-1 → 0, with no carry into higher bits.
- Data capture:
  - The RAM registers the address at the edge ending issue cycle N.
  - `mem_readdata` is valid during N+1 and is pushed into the FIFO at the end of N+1.
  - `inflight` is at most 1 outstanding read.
- The credit rule guarantees the FIFO never overflows. Push and pop in the same cycle leave the count unchanged.
- `out_last` is stored per entry, set on the entry from the final issued read.
- Stream rules:
  - `out_data` and `out_last` hold stable while `out_valid` is high and `out_ready` is low.
  - `out_valid` never drops without a pop.
- Commands are not queued. `cmd_valid` outside IDLE is ignored and not acknowledged.
- Reset at any time:
  - FIFO emptied, counters cleared, state IDLE, pending `done` cancelled.
  - No partial stream resumes after reset is released.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `mem_chipselect`=0, `mem_address`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0, `done`=0.
- Command accepted at edge ending cycle C (`cmd_valid` & `cmd_ready`):
  - C+1: first read issued; `busy`=1.
  - C+2: readdata valid.
  - C+3: `out_valid`=1.
  - Accept-to-first-data latency is 3 cycles.
- With `out_ready` held high: one halfword per cycle, with `mem_chipselect` high for exactly len consecutive cycles.
- Last word popped at edge ending cycle L:
  - L+1: `done`=1 for one cycle, `busy`=0, `cmd_ready`=1.
  - A new command may be accepted in L+1.
- len=0 accepted in cycle C: `done`=1 in C+1. No `mem_chipselect`, no `out_valid`, `busy` stays 0.

## Test plan
1. Preload halfwords 0x0100–0x0103 with 0xA000–0xA003. Issue cmd addr=0x0100, len=4 with `out_ready`=1. Required: `out_valid` at C+3; data 0xA000..0xA003 on consecutive cycles; `out_last` only with 0xA003; `mem_chipselect` high exactly 4 cycles; `done` one cycle after the last pop.
2. Issue len=8 with `out_ready` low for 10 cycles, then toggling 1,0. Required:
   - Reads stall with `fifo_count` ≤ 4.
   - All 8 words delivered in order with no loss or duplicate.
   - `out_data` stable across each stall.
3. Issue addr=20478, len=4. Required: `mem_address` sequence 20478, 20479, 0, 1; data matches those locations.
4. Issue len=0. Required: `done` pulses at C+1; no `mem_chipselect`, no `out_valid`; `busy` stays 0.
5. Assert `reset` after 3 of 8 words are popped. Required: all outputs take reset values immediately. A following cmd addr=0x0200, len=2 streams exactly 2 correct words with `out_last` on the second.
6. Hold `cmd_valid` high with two queued commands, len=2 and len=3. Required: the second is accepted in the `done` cycle of the first; 5 words delivered; `out_last` asserted twice.

Source files
------------

// File: rtl/processing_mem_stream_reader.sv
// processing_mem_stream_reader: Avalon-MM read master draining consecutive halfwords from the s2 port into a valid/ready stream
module processing_mem_stream_reader #(
   parameter int MEM_WORDS  = 20480,
   parameter int ADDR_W     = 15,
   parameter int LEN_W      = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [1:0]        mem_byteenable,
   output logic [15:0]       mem_writedata,
   input  logic [15:0]       mem_readdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_cs;
   logic              r_cs_last;
   logic              r_rd_vld;
   logic              r_rd_last;
   logic              r_done;
   logic [15:0]       r_data [FIFO_DEPTH];
   logic              r_last [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_rp;
   logic [PTR_W-1:0]  r_wp;
   logic [PTR_W:0]    r_count;

   logic              w_pop;
   logic              w_push;
   logic              w_credit;
   logic              w_issue;
   logic [ADDR_W-1:0] w_next_addr;

   // Credit counts FIFO entries plus the read sitting in the RAM this cycle; the read whose data
   // is being pushed right now is the one extra slot that keeps the 4-entry buffer from overflowing.
   assign w_credit    = r_cs ? (r_count <= (PTR_W+1)'(1)) : (r_count <= (PTR_W+1)'(2));
   assign w_issue     = (r_remaining != '0) && w_credit;
   assign w_next_addr = (r_addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : r_addr + ADDR_W'(1);
   assign w_push      = r_rd_vld;
   assign w_pop       = out_valid && out_ready;

   assign cmd_ready      = (r_state == IDLE);
   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign mem_address    = r_addr;
   assign mem_chipselect = r_cs;
   assign mem_clken      = 1'b1;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 2'b11;
   assign mem_writedata  = '0;
   assign out_valid      = (r_count != '0);
   assign out_data       = r_data[r_rp];
   assign out_last       = out_valid && r_last[r_rp];

   // Command FSM, registered read issue and the one-cycle read-data pipeline stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_cs        <= 1'b0;
         r_cs_last   <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_rd_last   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cs      <= 1'b0;
         r_rd_vld  <= r_cs;
         r_rd_last <= r_cs && r_cs_last;
         case (r_state)
            IDLE: if (cmd_valid) begin
               if (cmd_len == '0) r_done <= 1'b1;
               else begin
                  r_state     <= READ;
                  r_cs        <= 1'b1;
                  r_addr      <= cmd_addr;
                  r_remaining <= cmd_len - LEN_W'(1);
                  r_cs_last   <= (cmd_len == LEN_W'(1));
               end
            end
            READ: begin
               r_cs <= w_issue;
               if (w_issue) begin
                  r_addr      <= w_next_addr;
                  r_remaining <= r_remaining - LEN_W'(1);
                  r_cs_last   <= (r_remaining == LEN_W'(1));
               end
               if (r_remaining == '0) r_state <= DRAIN;
            end
            DRAIN: if (w_pop && out_last) begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Output FIFO holding each halfword with its end-of-command marker
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_data[i] <= '0;
            r_last[i] <= 1'b0;
         end
         r_rp    <= '0;
         r_wp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_data[r_wp] <= mem_readdata;
            r_last[r_wp] <= r_rd_last;
            r_wp         <= r_wp + PTR_W'(1);
         end
         if (w_pop) r_rp <= r_rp + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
   end
endmodule

// File: tb/tb_processing_mem_stream_reader.sv
// tb_processing_mem_stream_reader: directed and randomized checks of the s2 stream reader against a queue model
module tb_processing_mem_stream_reader;
   localparam int MW = 20480;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [14:0] cmd_addr = '0;
   logic [14:0] cmd_len = '0;
   logic [14:0] mem_address;
   logic        mem_chipselect;
   logic        mem_clken;
   logic        mem_write;
   logic [1:0]  mem_byteenable;
   logic [15:0] mem_writedata;
   logic [15:0] mem_readdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [15:0] mem [MW];
   logic [15:0] r_q;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] d;
      logic        l;
      logic        f;
      int          c;
   } item_t;

   item_t exp_q[$];
   int    addr_q[$];
   int    cmd_a[4];
   int    cmd_l[4];

   processing_mem_stream_reader dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_address(mem_address),
      .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // RAM registers the address every cycle; read data shows up the cycle after
   always @(posedge clk) r_q <= mem[mem_address];
   assign mem_readdata = r_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_chipselect", mem_chipselect, 0);
      check("rst_address", mem_address, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("const_clken", mem_clken, 1);
      check("const_write", mem_write, 0);
      check("const_byteenable", mem_byteenable, 2'b11);
      check("const_writedata", mem_writedata, 0);
   endtask

   // mode 0: ready always high; 1: low 10 cycles then toggling; 2: random
   task automatic run(input int ncmd, input int mode, input int abort_after);
      int    ci = 0, k = 0, pops = 0, tail = 3, cs_n = 0, cs_first = -1, cs_last = -1;
      int    nlast = 0, total = 0, nz = 0;
      int    acc[4];
      logic  busy_e = 0, done_e = 0, done_n = 0, acc_prev = 0, front_seen = 0;
      logic [15:0] prev_d = '0;
      item_t it;
      for (int j = 0; j < ncmd; j++) begin
         total += cmd_l[j];
         if (cmd_l[j] != 0) nz++;
      end
      while (1) begin
         @(negedge clk);
         if (k == 0 || acc_prev) begin
            if (ci < ncmd) begin
               cmd_addr  = 15'(cmd_a[ci]);
               cmd_len   = 15'(cmd_l[ci]);
               cmd_valid = 1'b1;
            end else cmd_valid = 1'b0;
         end
         acc_prev  = 0;
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k >= 10 && (k - 10) % 2 == 0) : ($urandom_range(0, 2) != 0);
         check("done", done, done_e);
         check("busy", busy, busy_e);
         check("cmd_ready", cmd_ready, !busy_e);
         done_n = 0;
         if (mem_chipselect) begin
            cs_n++;
            if (cs_first < 0) cs_first = k;
            cs_last = k;
            if (addr_q.size() == 0) check("cs_extra", mem_chipselect, 0);
            else check("mem_address", mem_address, addr_q.pop_front());
         end
         if (out_valid) begin
            if (exp_q.size() == 0) check("valid_extra", out_valid, 0);
            else begin
               it = exp_q[0];
               if (front_seen) check("hold", out_data, prev_d);
               else if (it.f) check("latency", k - acc[it.c], 3);
               check("out_data", out_data, it.d);
               check("out_last", out_last, it.l);
               front_seen = 1;
               prev_d = out_data;
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  front_seen = 0;
                  pops++;
                  if (it.l) begin
                     nlast++;
                     done_n = 1;
                     busy_e = 0;
                  end
               end
            end
         end else check("last_no_valid", out_last, 0);
         if (cmd_valid && cmd_ready) begin
            acc[ci]  = k;
            acc_prev = 1;
            if (ci > 0) check("accept_in_done", done, 1);
            for (int i = 0; i < cmd_l[ci]; i++) begin
               int a;
               a = (cmd_a[ci] + i) % MW;
               addr_q.push_back(a);
               it.d = mem[a];
               it.l = (i == cmd_l[ci] - 1);
               it.f = (i == 0);
               it.c = ci;
               exp_q.push_back(it);
            end
            if (cmd_l[ci] == 0) done_n = 1;
            else busy_e = 1;
            ci++;
         end
         done_e = done_n;
         k++;
         if (abort_after > 0 && pops == abort_after) break;
         if (ci == ncmd && !busy_e && !done_e && exp_q.size() == 0) begin
            tail--;
            if (tail == 0) break;
         end
         if (k >= 3000) begin
            check("timeout", 32'(k), 0);
            break;
         end
      end
      cmd_valid = 1'b0;
      if (abort_after > 0) begin
         @(negedge clk);
         reset = 1'b1;
         #1;
         check_reset();
         repeat (2) @(negedge clk);
         check_reset();
         reset = 1'b0;
         exp_q.delete();
         addr_q.delete();
      end else begin
         check("cs_count", cs_n, total);
         check("last_count", nlast, nz);
         if (mode == 0 && ncmd == 1 && total > 0) check("cs_span", cs_last - cs_first + 1, total);
      end
   endtask

   initial begin
      for (int i = 0; i < MW; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 4; i++) mem[256 + i] = 16'hA000 + 16'(i);
      @(negedge clk);
      check_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset();
      cmd_a[0] = 256; cmd_l[0] = 4;
      run(1, 0, 0);
      cmd_a[0] = $urandom_range(0, MW - 9); cmd_l[0] = 8;
      run(1, 1, 0);
      cmd_a[0] = 20478; cmd_l[0] = 4;
      run(1, 0, 0);
      cmd_a[0] = 5; cmd_l[0] = 0;
      run(1, 0, 0);
      cmd_a[0] = 12'h300; cmd_l[0] = 8;
      run(1, 0, 3);
      cmd_a[0] = 12'h200; cmd_l[0] = 2;
      run(1, 0, 0);
      cmd_a[0] = 1000; cmd_l[0] = 2; cmd_a[1] = 20479; cmd_l[1] = 3;
      run(2, 0, 0);
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            cmd_a[j] = ($urandom_range(0, 1) == 1) ? $urandom_range(MW - 6, MW - 1) : $urandom_range(0, MW - 1);
            cmd_l[j] = $urandom_range(0, 12);
         end
         run(n, 2, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
